// File: rtl/eight_bit_subtractor_pkg.sv
// rtl/eight_bit_subtractor_pkg.sv - shared width constant and result type for the subtractor
package eight_bit_subtractor_pkg;

    localparam int SUB_W = 8;

    typedef struct packed {
        logic [SUB_W-1:0] diff;
        logic             overflow;
        logic             cout;
    } sub_result_t;

endpackage

// File: rtl/eight_bit_subtractor_if.sv
// rtl/eight_bit_subtractor_if.sv - operand/result bundle for the subtractor
interface eight_bit_subtractor_if;
    import eight_bit_subtractor_pkg::*;

    logic             in_valid;
    logic [SUB_W-1:0] A;
    logic [SUB_W-1:0] B;
    logic [SUB_W-1:0] diff;
    logic             overflow;
    logic             cout;
    logic             out_valid;

    modport master (
        output in_valid, A, B,
        input  diff, overflow, cout, out_valid
    );

    modport slave (
        input  in_valid, A, B,
        output diff, overflow, cout, out_valid
    );
endinterface

// File: rtl/eight_bit_subtractor_full_adder.sv
// rtl/eight_bit_subtractor_full_adder.sv - one-bit full adder cell of the ripple chain
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

// File: rtl/eight_bit_subtractor.sv
// rtl/eight_bit_subtractor.sv - registered A - B via ripple adders on A + ~B + 1
module eight_bit_subtractor
    import eight_bit_subtractor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    eight_bit_subtractor_if.slave bus
);

    logic [SUB_W-1:0] b_inv;
    logic [SUB_W-1:0] sum;
    logic [SUB_W:0]   carry;

    sub_result_t res_d, res_q;
    logic        valid_d, valid_q;

    assign b_inv    = ~bus.B;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < SUB_W; i++) begin : g_fa
        full_adder u_fa (
            .a   (bus.A[i]),
            .b   (b_inv[i]),
            .cin (carry[i]),
            .s   (sum[i]),
            .cout(carry[i+1])
        );
    end

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        res_d   = res_q;
        valid_d = 1'b0;
        if (bus.in_valid) begin
            res_d.diff     = sum;
            res_d.cout     = carry[SUB_W];
            res_d.overflow = carry[SUB_W-1] ^ carry[SUB_W];
            valid_d        = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            res_q   <= res_d;
            valid_q <= valid_d;
        end
    end

    assign bus.diff      = res_q.diff;
    assign bus.overflow  = res_q.overflow;
    assign bus.cout      = res_q.cout;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_eight_bit_subtractor.sv
// tb/tb_eight_bit_subtractor.sv - scoreboard bench for eight_bit_subtractor
module tb_eight_bit_subtractor;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    eight_bit_subtractor_if bus ();

    eight_bit_subtractor dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // {diff, overflow, cout}
    logic [9:0] exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[7] = '{
        '{8'h36, 8'h0F, {8'h27, 1'b0, 1'b1}},
        '{8'h80, 8'h01, {8'h7F, 1'b1, 1'b1}},
        '{8'h7F, 8'hFF, {8'h80, 1'b1, 1'b0}},
        '{8'h05, 8'h05, {8'h00, 1'b0, 1'b1}},
        '{8'h00, 8'h01, {8'hFF, 1'b0, 1'b0}},
        '{8'h5A, 8'h00, {8'h5A, 1'b0, 1'b1}},
        '{8'h01, 8'h80, {8'h81, 1'b1, 1'b0}}
    };

    function automatic logic [9:0] ref_model(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        logic       ov;
        logic       c;
        d  = a - b;
        c  = (a >= b);
        ov = (a[7] != b[7]) && (d[7] != a[7]);
        return {d, ov, c};
    endfunction

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [9:0] e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [7:0] a, input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.A        = a;
        bus.B        = b;
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out_valid got=%h want=none",
                         {bus.diff, bus.overflow, bus.cout});
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                if ({bus.diff, bus.overflow, bus.cout} !== e) begin
                    failures++;
                    $display("FAIL result got={diff,ovf,cout}=%h want=%h",
                             {bus.diff, bus.overflow, bus.cout}, e);
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.A        = 8'h00;
        bus.B        = 8'h00;
        #22;
        check("reset_state", {bus.diff, bus.overflow, bus.cout, bus.out_valid}, 11'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].exp);

        // Hold: load, then drop in_valid with new operands applied.
        issue(8'h36, 8'h0F, {8'h27, 1'b0, 1'b1});
        idle(8'h11, 8'h22);
        @(posedge clk);
        #1;
        check("hold_values", {bus.diff, bus.overflow, bus.cout, bus.out_valid},
              {8'h27, 1'b0, 1'b1, 1'b0});

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {bus.diff, bus.overflow, bus.cout, bus.out_valid}, 11'h0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(8'h36, 8'h0F, {8'h27, 1'b0, 1'b1});
        for (int i = 0; i < 65536; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = i[15:8];
            b = i[7:0];
            issue(a, b, ref_model(a, b));
        end
        idle(8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 11'(exp_q.size()), 11'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
